// File: rtl/alu_pkg.sv
// Shared encodings for the ALU op sequencer: ALU op codes, MIPS opcode/funct
// fields, operand-select encodings and FSM states.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_NOR = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_INC = 4'b0101;
  localparam logic [3:0] ALU_MUL = 4'b0110;
  localparam logic [3:0] ALU_MOV = 4'b0111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_MUL = 6'h18;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;

  localparam logic       SRCA_PC     = 1'b0;
  localparam logic       SRCA_RS     = 1'b1;
  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_COMPLETE,
    ST_BRANCH,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational opcode/funct decode into ALU operation and instruction class.
module alu_op_decoder
  import alu_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_operation,
  output logic       is_branch,
  output logic       is_bne,
  output logic       uses_imm,
  output logic       imm_shift,
  output logic       illegal
);

  always_comb begin
    alu_operation = ALU_AND;
    is_branch     = 1'b0;
    is_bne        = 1'b0;
    uses_imm      = 1'b0;
    illegal       = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_operation = ALU_ADD;
          FN_SUB:  alu_operation = ALU_SUB;
          FN_AND:  alu_operation = ALU_AND;
          FN_OR:   alu_operation = ALU_OR;
          FN_NOR:  alu_operation = ALU_NOR;
          FN_MUL:  alu_operation = ALU_MUL;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin alu_operation = ALU_ADD; uses_imm = 1'b1; end
      OP_ANDI: begin alu_operation = ALU_AND; uses_imm = 1'b1; end
      OP_ORI:  begin alu_operation = ALU_OR;  uses_imm = 1'b1; end
      OP_LUI:  begin alu_operation = ALU_MOV; uses_imm = 1'b1; end
      OP_BEQ:  begin alu_operation = ALU_SUB; is_branch = 1'b1; end
      OP_BNE:  begin alu_operation = ALU_SUB; is_branch = 1'b1; is_bne = 1'b1; end
      default: illegal = 1'b1;
    endcase
    // Branch immediates are word offsets; ALU-type immediates are used as-is.
    imm_shift = is_branch;
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Multicycle FETCH/DECODE/EXECUTE/COMPLETE sequencer driving the ALU selects
// and producing PC/register write strobes for the datapath.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ALU_OP_WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    instr_valid,
  output logic                    instr_ready,
  input  logic [5:0]              opcode,
  input  logic [5:0]              funct,
  output logic [ALU_OP_WIDTH-1:0] alu_operation,
  output logic                    alu_src_a_sel,
  output logic [1:0]              alu_src_b_sel,
  input  logic [DATA_WIDTH-1:0]   alu_result,
  input  logic                    alu_zero,
  output logic                    pc_write,
  output logic                    pc_write_target,
  output logic                    reg_write,
  output logic [DATA_WIDTH-1:0]   result_q,
  output logic [DATA_WIDTH-1:0]   target_q,
  output logic                    illegal,
  output logic                    busy
);

  state_e                  state_q, state_d;
  logic [5:0]              opcode_q, opcode_d;
  logic [5:0]              funct_q, funct_d;
  logic [DATA_WIDTH-1:0]   result_d, target_d;

  logic [3:0] dec_op;
  logic       dec_is_branch, dec_is_bne, dec_uses_imm, dec_imm_shift, dec_illegal;

  alu_op_decoder u_decoder (
    .opcode        (opcode_q),
    .funct         (funct_q),
    .alu_operation (dec_op),
    .is_branch     (dec_is_branch),
    .is_bne        (dec_is_bne),
    .uses_imm      (dec_uses_imm),
    .imm_shift     (dec_imm_shift),
    .illegal       (dec_illegal)
  );

  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    funct_d  = funct_q;
    result_d = result_q;
    target_d = target_q;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          opcode_d = opcode;
          funct_d  = funct;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        target_d = alu_result;
        if (dec_illegal)        state_d = ST_ERROR;
        else if (dec_is_branch) state_d = ST_BRANCH;
        else                    state_d = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        result_d = alu_result;
        state_d  = ST_COMPLETE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes are masked by reset so an aborted instruction never writes.
  always_comb begin
    alu_operation   = ALU_AND;
    alu_src_a_sel   = SRCA_PC;
    alu_src_b_sel   = SRCB_RT;
    pc_write        = 1'b0;
    pc_write_target = 1'b0;
    reg_write       = 1'b0;
    illegal         = 1'b0;
    case (state_q)
      ST_FETCH: begin
        alu_operation = ALU_ADD;
        alu_src_b_sel = SRCB_FOUR;
        pc_write      = !reset;
      end
      ST_DECODE: begin
        alu_operation = ALU_ADD;
        alu_src_b_sel = SRCB_IMM_SH;
      end
      ST_EXECUTE: begin
        alu_operation = dec_op;
        alu_src_a_sel = SRCA_RS;
        if (dec_uses_imm) alu_src_b_sel = dec_imm_shift ? SRCB_IMM_SH : SRCB_IMM;
      end
      ST_COMPLETE: reg_write = !reset;
      ST_BRANCH: begin
        alu_operation   = ALU_SUB;
        alu_src_a_sel   = SRCA_RS;
        pc_write_target = !reset && (alu_zero ^ dec_is_bne);
      end
      ST_ERROR: illegal = !reset;
      default: ;
    endcase
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      opcode_q <= '0;
      funct_q  <= '0;
      result_q <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      funct_q  <= funct_d;
      result_q <= result_d;
      target_q <= target_d;
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer with a behavioural ALU
// environment and an instruction-level reference model.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset, instr_valid, instr_ready;
  logic [5:0]  opcode, funct;
  logic [3:0]  alu_operation;
  logic        alu_src_a_sel;
  logic [1:0]  alu_src_b_sel;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        pc_write, pc_write_target, reg_write, illegal, busy;
  logic [31:0] result_q, target_q;

  logic [31:0] env_pc, env_rs, env_rt;
  logic [15:0] env_imm;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] m_result, m_target;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DATA_WIDTH(32), .ALU_OP_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .funct(funct), .alu_operation(alu_operation),
    .alu_src_a_sel(alu_src_a_sel), .alu_src_b_sel(alu_src_b_sel),
    .alu_result(alu_result), .alu_zero(alu_zero), .pc_write(pc_write),
    .pc_write_target(pc_write_target), .reg_write(reg_write),
    .result_q(result_q), .target_q(target_q), .illegal(illegal), .busy(busy)
  );

  // Behavioural 32-bit ALU plus operand muxes around the sequencer.
  always_comb begin
    logic [31:0] a, b, simm;
    simm = {{16{env_imm[15]}}, env_imm};
    a = alu_src_a_sel ? env_rs : env_pc;
    case (alu_src_b_sel)
      2'b00:   b = env_rt;
      2'b01:   b = 32'd4;
      2'b10:   b = simm;
      default: b = simm << 2;
    endcase
    case (alu_operation)
      4'd0:    alu_result = a & b;
      4'd1:    alu_result = a | b;
      4'd2:    alu_result = ~(a | b);
      4'd3:    alu_result = a + b;
      4'd4:    alu_result = a - b;
      4'd5:    alu_result = a + 32'd1;
      4'd6:    alu_result = a * b;
      4'd7:    alu_result = b;
      default: alu_result = '0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [1:0]  kind;   // 0 = ALU op, 1 = branch, 2 = illegal
    logic [3:0]  op;
    logic        uses_imm;
    logic        taken;
    logic [31:0] value;
  } ref_t;

  function automatic ref_t ref_model(input logic [5:0] opc, input logic [5:0] fn,
                                     input logic [31:0] rs, input logic [31:0] rt,
                                     input logic [15:0] imm);
    ref_t r;
    logic [31:0] simm;
    simm = {{16{imm[15]}}, imm};
    r = '0;
    r.kind = 2'd2;
    case (opc)
      6'h00: begin
        r.kind = 2'd0;
        case (fn)
          6'h20: begin r.op = 4'd3; r.value = rs + rt; end
          6'h22: begin r.op = 4'd4; r.value = rs - rt; end
          6'h24: begin r.op = 4'd0; r.value = rs & rt; end
          6'h25: begin r.op = 4'd1; r.value = rs | rt; end
          6'h27: begin r.op = 4'd2; r.value = ~(rs | rt); end
          6'h18: begin r.op = 4'd6; r.value = rs * rt; end
          default: r.kind = 2'd2;
        endcase
      end
      6'h08: begin r.kind = 2'd0; r.op = 4'd3; r.uses_imm = 1'b1; r.value = rs + simm; end
      6'h0C: begin r.kind = 2'd0; r.op = 4'd0; r.uses_imm = 1'b1; r.value = rs & simm; end
      6'h0D: begin r.kind = 2'd0; r.op = 4'd1; r.uses_imm = 1'b1; r.value = rs | simm; end
      6'h0F: begin r.kind = 2'd0; r.op = 4'd7; r.uses_imm = 1'b1; r.value = simm; end
      6'h04: begin r.kind = 2'd1; r.op = 4'd4; r.taken = (rs == rt); end
      6'h05: begin r.kind = 2'd1; r.op = 4'd4; r.taken = (rs != rt); end
      default: ;
    endcase
    return r;
  endfunction

  // Called at a negedge with the DUT idle; rst_at = cycle after accept at which
  // reset is raised (0 = never).
  task automatic run_instr(input logic [5:0] opc, input logic [5:0] fn,
                           input logic [31:0] pc, input logic [31:0] rs,
                           input logic [31:0] rt, input logic [15:0] imm,
                           input int unsigned rst_at);
    ref_t r;
    int unsigned lat;
    logic [5:0] exp_strb;
    logic [6:0] exp_ctrl;
    logic [31:0] simm;
    env_pc = pc; env_rs = rs; env_rt = rt; env_imm = imm;
    simm = {{16{imm[15]}}, imm};
    r = ref_model(opc, fn, rs, rt, imm);
    lat = (r.kind == 2'd0) ? 4 : 3;
    check_eq("ready_before", {31'd0, instr_ready}, 32'd1);
    instr_valid = 1'b1; opcode = opc; funct = fn;
    for (int unsigned k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (k <= lat) begin
        exp_strb = {1'b0, 1'b1, k == 1, r.kind == 2'd1 && k == 3 && r.taken,
                    r.kind == 2'd0 && k == 4, r.kind == 2'd2 && k == 3};
        case (k)
          1: exp_ctrl = {4'd3, 1'b0, 2'b01};
          2: exp_ctrl = {4'd3, 1'b0, 2'b11};
          3: exp_ctrl = (r.kind == 2'd0) ? {r.op, 1'b1, r.uses_imm ? 2'b10 : 2'b00} :
                        (r.kind == 2'd1) ? {4'd4, 1'b1, 2'b00} : 7'd0;
          default: exp_ctrl = 7'd0;
        endcase
        check_eq($sformatf("strobes_c%0d_op%0h", k, opc),
                 {26'd0, instr_ready, busy, pc_write, pc_write_target, reg_write, illegal},
                 {26'd0, exp_strb});
        check_eq($sformatf("ctrl_c%0d_op%0h", k, opc),
                 {25'd0, alu_operation, alu_src_a_sel, alu_src_b_sel}, {25'd0, exp_ctrl});
        opcode = 6'($urandom); funct = 6'($urandom);
        if (k == 2 || k == lat) m_target = pc + (simm << 2);
        if (rst_at == k) begin
          reset = 1'b1; instr_valid = 1'b0;
          #1 check_eq("rst_cycle_strobes",
                      {28'd0, pc_write, pc_write_target, reg_write, illegal}, 32'd0);
          @(negedge clk);
          reset = 1'b0;
          m_result = '0; m_target = '0;
          check_eq("rst_abort_state",
                   {26'd0, instr_ready, busy, pc_write, pc_write_target, reg_write, illegal},
                   32'b100000);
          check_eq("rst_abort_ctrl", {25'd0, alu_operation, alu_src_a_sel, alu_src_b_sel}, 32'd0);
          check_eq("rst_abort_result", result_q, 32'd0);
          check_eq("rst_abort_target", target_q, 32'd0);
          return;
        end
      end else begin
        instr_valid = 1'b0;
        if (r.kind == 2'd0) m_result = r.value;
        check_eq($sformatf("idle_strobes_op%0h", opc),
                 {26'd0, instr_ready, busy, pc_write, pc_write_target, reg_write, illegal},
                 32'b100000);
        check_eq("idle_ctrl", {25'd0, alu_operation, alu_src_a_sel, alu_src_b_sel}, 32'd0);
        check_eq($sformatf("result_q_op%0h_fn%0h", opc, fn), result_q, m_result);
        check_eq($sformatf("target_q_op%0h", opc), target_q, m_target);
      end
    end
  endtask

  initial begin
    logic [5:0] opc_tab [9];
    logic [5:0] fn_tab [7];
    logic [5:0] o, f;
    logic [31:0] rs;
    opc_tab = '{6'h00, 6'h00, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h3F};
    fn_tab  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h18, 6'h21};
    reset = 1'b1; instr_valid = 1'b0; opcode = '0; funct = '0;
    env_pc = '0; env_rs = '0; env_rt = '0; env_imm = '0;
    m_result = '0; m_target = '0;
    repeat (2) @(negedge clk);
    check_eq("reset_state",
             {26'd0, instr_ready, busy, pc_write, pc_write_target, reg_write, illegal}, 32'b100000);
    check_eq("reset_ctrl", {25'd0, alu_operation, alu_src_a_sel, alu_src_b_sel}, 32'd0);
    check_eq("reset_result", result_q, 32'd0);
    check_eq("reset_target", target_q, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_instr(6'h00, 6'h20, 32'h100, 32'd5, 32'd7, 16'h0001, 0);
    check_eq("add_5_7", result_q, 32'd12);
    run_instr(6'h04, 6'h00, 32'h100, 32'd9, 32'd9, 16'h0003, 0);
    check_eq("beq_target", target_q, 32'h10C);
    run_instr(6'h05, 6'h00, 32'h100, 32'd9, 32'd9, 16'h0003, 0);
    run_instr(6'h0F, 6'h00, 32'h200, 32'd1, 32'd2, 16'h8001, 0);
    run_instr(6'h0D, 6'h00, 32'h204, 32'hF0, 32'd2, 16'h000F, 0);
    run_instr(6'h00, 6'h22, 32'h208, 32'd6, 32'd6, 16'h0000, 0);
    run_instr(6'h3F, 6'h00, 32'h20C, 32'd1, 32'd2, 16'hFFFF, 0);
    run_instr(6'h00, 6'h21, 32'h210, 32'd1, 32'd2, 16'h0004, 0);
    run_instr(6'h00, 6'h20, 32'h214, 32'd3, 32'd4, 16'h0001, 3);
    run_instr(6'h00, 6'h25, 32'h218, 32'd3, 32'd4, 16'h0001, 4);
    run_instr(6'h04, 6'h00, 32'h21C, 32'd3, 32'd3, 16'h0002, 3);
    @(negedge clk);

    for (int unsigned i = 0; i < 80; i++) begin
      o  = opc_tab[$urandom_range(8)];
      f  = fn_tab[$urandom_range(6)];
      if ($urandom_range(9) == 0) o = 6'($urandom);
      rs = $urandom;
      run_instr(o, f, $urandom & 32'hFFFF_FFFC, rs, ($urandom_range(1) == 1) ? rs : $urandom,
                16'($urandom), 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
